ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
Pipeline controller for the execute stage. It tracks destination registers of in-flight instructions and generates the registered one-hot forwarding selects f_rs1/f_rs2 consumed by the EX datapath. It detects load-use hazards and inserts one bubble, sequences multi-cycle EX operations (mul/div) with a start/done handshake and watchdog, and flushes younger stages on taken branches. It sits beside the ID/EX and EX/MEM pipeline registers and drives their hold/bubble controls.

Parameters:
MC_MAX_LAT, 32, watchdog limit in cycles for a multi-cycle op before forced completion.
REG_AW, 5, register index width.

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
id_valid  in  1  valid instruction in ID
id_rs1  in  REG_AW  ID source 1 index
id_rs2  in  REG_AW  ID source 2 index
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
id_rd  in  REG_AW  ID destination index
id_reg_write  in  1  ID instruction writes rd
id_is_load  in  1  ID instruction is a load
id_is_mc  in  1  ID instruction is multi-cycle
branch_taken  in  1  branch in EX resolved taken
mc_done  in  1  multi-cycle unit result valid
f_rs1  out  2  rs1 forward select for EX; bit0=EX/MEM, bit1=MEM/WB
f_rs2  out  2  same encoding for rs2
stall_front  out  1  hold PC and IF/ID
flush_ifid  out  1  zero IF/ID
hold_idex  out  1  hold ID/EX, including f_rs* regs
bubble_idex  out  1  load NOP into ID/EX
bubble_exmem  out  1  load NOP into EX/MEM
mc_start  out  1  one-cycle pulse; mc unit latches operands
mc_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: all outputs 0. State RUN. EX and MEM shadow entries invalid. Counter 0. mc_timeout is cleared only by reset.
- Shadows: EX shadow holds {valid, rd, reg_write, is_load}; MEM shadow holds {valid, rd, reg_write}. They advance each cycle unless held. A bubble writes valid=0.
- Match: an EX or MEM match requires shadow valid & reg_write & rd==rs & rs!=0 & uses_rs.
- Forwarding selects are computed in ID and registered on ID->EX advance.
  - bit0 = EX-shadow match.
  - bit1 = MEM-shadow match & !bit0 (youngest producer wins).
  - Never both set. Selects become 00 on bubble and are held while hold_idex=1.
- Load-use: in RUN, if id_valid and EX-shadow is_load matches rs1 or rs2, assert stall_front=1 and bubble_idex=1 for exactly 1 cycle (state LU_STALL). Next cycle the consumer advances with select bit1 (load now in WB).
- Multi-cycle: when an id_is_mc instruction advances to EX, go to MC_BUSY next cycle.
  - mc_start=1 on the first MC_BUSY cycle only.
  - While in MC_BUSY: stall_front=1, hold_idex=1, bubble_exmem=1; MEM shadow is invalidated; counter increments.
  - Exit to RUN in the cycle mc_done=1, or when counter==MC_MAX_LAT-1 (also set mc_timeout). In that exit cycle bubble_exmem=0, hold_idex=0, stall_front=0. Counter resets to 0.
- Branch: branch_taken in RUN gives flush_ifid=1 and bubble_idex=1 in the same cycle (combinational). The ID instruction is discarded, and no load-use stall or MC entry is taken for it.
- Priority: reset > MC_BUSY > branch_taken > load-use > normal advance. branch_taken during MC_BUSY is illegal; it is ignored and a bench assertion fires.
- Load-use and id_is_mc together: LU_STALL first, then enter MC_BUSY when the op advances.
- Reset mid-MC_BUSY: immediate return to RUN, mc_start not reissued, shadows invalid.
- mc_done outside MC_BUSY is ignored.

Decomposition:
- Package ex_ctrl_pkg holds:
  - state enum {RUN, LU_STALL, MC_BUSY};
  - FWD_NONE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10;
  - REG_X0=0;
  - shadow-entry struct.
- Sub-module fwd_match: a combinational comparator instantiated four times (rs1/rs2 × EX/MEM). The FSM and counter stay in the top module.

Test Plan:
1. Back-to-back ALU dependency: add x5 then sub x6,x5 -> consumer enters EX with f_rs1=01; no stall.
2. Distance-2 dependency: add x5; nop; or x7,x5 -> f_rs1=10. Same case with rd=x0 -> f_rs1=00.
3. Load-use: lw x3 then add x4,x3 -> one cycle with stall_front=1 and bubble_idex=1, then consumer in EX with f_rs2/f_rs1=10; total penalty 1 cycle.
4. MC op: mul, then mc_done asserted 5 cycles after mc_start -> mc_start pulses once, stall_front high 5 cycles, bubble_exmem high 5 cycles then 0, mc_timeout=0.
5. Watchdog: mul with mc_done never asserted, MC_MAX_LAT=8 -> exit after 8 MC_BUSY cycles, mc_timeout=1 and sticky until reset.
6. Branch + load-use collision: branch_taken with a dependent load consumer in ID -> flush_ifid=1, bubble_idex=1, no LU_STALL entry. Reset asserted mid-MC_BUSY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ex_ctrl_pkg.sv
// Shared types and constants for the execute-stage hazard controller.
// Shadow entries carry only the per-instruction flags; rd travels beside them at REG_AW width.
package ex_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MC_BUSY  = 2'd2
  } state_e;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int REG_X0 = 0;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic is_load;
  } ex_shadow_t;

  typedef struct packed {
    logic valid;
    logic reg_write;
  } mem_shadow_t;

  // The youngest producer wins, so the two select bits are never set together.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (ex_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Compares one ID source operand against one in-flight shadow entry.
// x0 is hard-wired to zero, so it never matches a producer.
module fwd_match
  import ex_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              valid_i,
  input  logic              reg_write_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic              uses_rs_i,
  output logic              match_o
);

  assign match_o = valid_i & reg_write_i & uses_rs_i &
                   (rd_i == rs_i) & (rs_i != REG_AW'(REG_X0));

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: forwarding selects, load-use bubble,
// multi-cycle op sequencing with watchdog, and taken-branch flush.
//
// state    | meaning
// RUN      | normal advance; branch flush and load-use detection active
// LU_STALL | one bubble already inserted; consumer advances, picks up load from MEM/WB
// MC_BUSY  | multi-cycle op in EX; front end and ID/EX held until done or watchdog
module ex_hazard_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int MC_MAX_LAT = 32,
  parameter int REG_AW     = 5
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_reg_write_i,
  input  logic              id_is_load_i,
  input  logic              id_is_mc_i,
  input  logic              branch_taken_i,
  input  logic              mc_done_i,
  output logic [1:0]        f_rs1_o,
  output logic [1:0]        f_rs2_o,
  output logic              stall_front_o,
  output logic              flush_ifid_o,
  output logic              hold_idex_o,
  output logic              bubble_idex_o,
  output logic              bubble_exmem_o,
  output logic              mc_start_o,
  output logic              mc_timeout_o
);

  localparam int CW = ($clog2(MC_MAX_LAT) < 1) ? 1 : $clog2(MC_MAX_LAT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MC_MAX_LAT - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  ex_shadow_t        ex_q, ex_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  mem_shadow_t       mem_q, mem_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic [1:0]        f1_q, f1_d;
  logic [1:0]        f2_q, f2_d;

  logic m_ex1, m_ex2, m_mem1, m_mem2;
  logic lu_hit;
  logic stall_c, flush_c, hold_c, bub_id_c, bub_mem_c, start_c, advance_c;

  fwd_match #(.REG_AW(REG_AW)) u_match_ex_rs1 (
    .valid_i    (ex_q.valid),
    .reg_write_i(ex_q.reg_write),
    .rd_i       (ex_rd_q),
    .rs_i       (id_rs1_i),
    .uses_rs_i  (id_uses_rs1_i),
    .match_o    (m_ex1)
  );

  fwd_match #(.REG_AW(REG_AW)) u_match_ex_rs2 (
    .valid_i    (ex_q.valid),
    .reg_write_i(ex_q.reg_write),
    .rd_i       (ex_rd_q),
    .rs_i       (id_rs2_i),
    .uses_rs_i  (id_uses_rs2_i),
    .match_o    (m_ex2)
  );

  fwd_match #(.REG_AW(REG_AW)) u_match_mem_rs1 (
    .valid_i    (mem_q.valid),
    .reg_write_i(mem_q.reg_write),
    .rd_i       (mem_rd_q),
    .rs_i       (id_rs1_i),
    .uses_rs_i  (id_uses_rs1_i),
    .match_o    (m_mem1)
  );

  fwd_match #(.REG_AW(REG_AW)) u_match_mem_rs2 (
    .valid_i    (mem_q.valid),
    .reg_write_i(mem_q.reg_write),
    .rd_i       (mem_rd_q),
    .rs_i       (id_rs2_i),
    .uses_rs_i  (id_uses_rs2_i),
    .match_o    (m_mem2)
  );

  assign lu_hit = id_valid_i & ex_q.is_load & (m_ex1 | m_ex2);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    stall_c   = 1'b0;
    flush_c   = 1'b0;
    hold_c    = 1'b0;
    bub_id_c  = 1'b0;
    bub_mem_c = 1'b0;
    start_c   = 1'b0;
    advance_c = 1'b0;

    unique case (state_q)
      MC_BUSY: begin
        start_c = (cnt_q == '0);
        if (mc_done_i || (cnt_q == CNT_LAST)) begin
          // Exit cycle: pipeline advances normally, the mc op moves on to MEM.
          if (!mc_done_i) begin
            timeout_d = 1'b1;
          end
          cnt_d     = '0;
          state_d   = RUN;
          advance_c = 1'b1;
        end else begin
          stall_c   = 1'b1;
          hold_c    = 1'b1;
          bub_mem_c = 1'b1;
          cnt_d     = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RUN;
        if (branch_taken_i) begin
          flush_c  = 1'b1;
          bub_id_c = 1'b1;
        end else if ((state_q == RUN) && lu_hit) begin
          stall_c  = 1'b1;
          bub_id_c = 1'b1;
          state_d  = LU_STALL;
        end else begin
          advance_c = 1'b1;
        end
      end
    endcase

    if (advance_c && id_valid_i && id_is_mc_i) begin
      state_d = MC_BUSY;
      cnt_d   = '0;
    end
  end

  always_comb begin
    ex_d     = ex_q;
    ex_rd_d  = ex_rd_q;
    mem_d    = mem_q;
    mem_rd_d = mem_rd_q;
    f1_d     = f1_q;
    f2_d     = f2_q;

    if (hold_c) begin
      mem_d = '0;
    end else if (bub_id_c) begin
      ex_d     = '0;
      mem_d    = '{valid: ex_q.valid, reg_write: ex_q.reg_write};
      mem_rd_d = ex_rd_q;
      f1_d     = FWD_NONE;
      f2_d     = FWD_NONE;
    end else begin
      ex_d     = '{valid: id_valid_i, reg_write: id_reg_write_i, is_load: id_is_load_i};
      ex_rd_d  = id_rd_i;
      mem_d    = '{valid: ex_q.valid, reg_write: ex_q.reg_write};
      mem_rd_d = ex_rd_q;
      f1_d     = id_valid_i ? fwd_sel(m_ex1, m_mem1) : FWD_NONE;
      f2_d     = id_valid_i ? fwd_sel(m_ex2, m_mem2) : FWD_NONE;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      ex_q      <= '0;
      ex_rd_q   <= '0;
      mem_q     <= '0;
      mem_rd_q  <= '0;
      f1_q      <= FWD_NONE;
      f2_q      <= FWD_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      ex_q      <= ex_d;
      ex_rd_q   <= ex_rd_d;
      mem_q     <= mem_d;
      mem_rd_q  <= mem_rd_d;
      f1_q      <= f1_d;
      f2_q      <= f2_d;
    end
  end

  // Combinational controls are forced low while reset is held, independent of inputs.
  assign stall_front_o  = reset_n_i & stall_c;
  assign flush_ifid_o   = reset_n_i & flush_c;
  assign hold_idex_o    = reset_n_i & hold_c;
  assign bubble_idex_o  = reset_n_i & bub_id_c;
  assign bubble_exmem_o = reset_n_i & bub_mem_c;
  assign mc_start_o     = reset_n_i & start_c;
  assign f_rs1_o        = f1_q;
  assign f_rs2_o        = f2_q;
  assign mc_timeout_o   = timeout_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl with hand-computed expectations.
module tb_ex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_uses_rs1, id_uses_rs2, id_reg_write, id_is_load, id_is_mc;
  logic       branch_taken, mc_done;
  logic [1:0] f_rs1, f_rs2;
  logic       stall_front, flush_ifid, hold_idex, bubble_idex, bubble_exmem;
  logic       mc_start, mc_timeout;

  int checks = 0;
  int errors = 0;
  int n_start, n_stall, n_be;

  always #5 clk = ~clk;

  ex_hazard_ctrl #(.MC_MAX_LAT(8), .REG_AW(5)) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .id_valid_i    (id_valid),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .id_rd_i       (id_rd),
    .id_reg_write_i(id_reg_write),
    .id_is_load_i  (id_is_load),
    .id_is_mc_i    (id_is_mc),
    .branch_taken_i(branch_taken),
    .mc_done_i     (mc_done),
    .f_rs1_o       (f_rs1),
    .f_rs2_o       (f_rs2),
    .stall_front_o (stall_front),
    .flush_ifid_o  (flush_ifid),
    .hold_idex_o   (hold_idex),
    .bubble_idex_o (bubble_idex),
    .bubble_exmem_o(bubble_exmem),
    .mc_start_o    (mc_start),
    .mc_timeout_o  (mc_timeout)
  );

  // A taken branch while the multi-cycle unit holds EX is a protocol violation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && hold_idex === 1'b1 && branch_taken === 1'b1) begin
      errors++;
      $error("FAIL illegal_branch_in_mc_busy observed=1 expected=0");
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idrv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic rw, input logic ld, input logic mc);
    id_valid     = v;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_uses_rs1  = u1;
    id_uses_rs2  = u2;
    id_rd        = rd;
    id_reg_write = rw;
    id_is_load   = ld;
    id_is_mc     = mc;
  endtask

  task automatic nop();
    idrv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] all_out();
    return {5'd0, f_rs1, f_rs2, stall_front, flush_ifid, hold_idex,
            bubble_idex, bubble_exmem, mc_start, mc_timeout};
  endfunction

  initial begin
    reset_n      = 1'b0;
    branch_taken = 1'b1;
    mc_done      = 1'b0;
    nop();
    #2;
    chk("reset_all_outputs", all_out(), 16'h0000);
    branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // back-to-back dependency: add x5; sub x6,x5,x1
    idrv(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0);
    #1 chk("t1_add_no_stall", {15'd0, stall_front}, 16'd0);
    tick();
    idrv(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0);
    #1 chk("t1_sub_no_stall", {15'd0, stall_front}, 16'd0);
    tick();
    chk("t1_f_rs1_exmem", {14'd0, f_rs1}, 16'h0001);
    chk("t1_f_rs2_none", {14'd0, f_rs2}, 16'h0000);

    // distance-2 dependency: add x5; nop; or x7,x5,x0
    idrv(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0);
    tick();
    nop();
    tick();
    idrv(1, 5'd5, 5'd0, 1, 1, 5'd7, 1, 0, 0);
    tick();
    chk("t2_f_rs1_memwb", {14'd0, f_rs1}, 16'h0002);
    chk("t2_f_rs2_x0", {14'd0, f_rs2}, 16'h0000);

    // same with rd = x0: no forwarding
    idrv(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0);
    tick();
    nop();
    tick();
    idrv(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0, 0);
    tick();
    chk("t2_rd_x0_f_rs1", {14'd0, f_rs1}, 16'h0000);

    // two producers of x5: youngest (EX) wins; rs2 not used
    idrv(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0);
    tick();
    idrv(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0);
    tick();
    idrv(1, 5'd5, 5'd5, 1, 0, 5'd9, 1, 0, 0);
    tick();
    chk("t2_youngest_wins", {14'd0, f_rs1}, 16'h0001);
    chk("t2_uses_rs2_off", {14'd0, f_rs2}, 16'h0000);

    // load-use: lw x3; add x4,x3,x3
    idrv(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1, 0);
    #1 chk("t3_lw_no_stall", {15'd0, stall_front}, 16'd0);
    tick();
    idrv(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0);
    #1 chk("t3_lu_stall_bubble", {14'd0, stall_front, bubble_idex}, 16'h0003);
    chk("t3_lu_no_flush", {15'd0, flush_ifid}, 16'd0);
    tick();
    #1 chk("t3_after_stall_ctl", {14'd0, stall_front, bubble_idex}, 16'h0000);
    chk("t3_bubble_selects", {12'd0, f_rs1, f_rs2}, 16'h0000);
    tick();
    chk("t3_consumer_selects", {12'd0, f_rs1, f_rs2}, 16'h000A);

    // mc_done outside MC_BUSY is ignored
    nop();
    mc_done = 1'b1;
    #1 chk("stray_done_same_cycle", {14'd0, stall_front, mc_start}, 16'h0000);
    tick();
    mc_done = 1'b0;
    #1 chk("stray_done_next", {13'd0, stall_front, hold_idex, mc_start}, 16'h0000);

    // multi-cycle op, done 5 cycles after mc_start; x8 consumer waits in ID
    idrv(1, 5'd1, 5'd2, 1, 1, 5'd8, 1, 0, 1);
    #1 chk("t4_mul_enter_no_stall", {15'd0, stall_front}, 16'd0);
    tick();
    idrv(1, 5'd8, 5'd0, 1, 0, 5'd10, 1, 0, 0);
    n_start = 0; n_stall = 0; n_be = 0;
    for (int i = 0; i < 6; i++) begin
      mc_done = (i == 5);
      #1;
      if (mc_start === 1'b1) n_start++;
      if (stall_front === 1'b1) n_stall++;
      if (bubble_exmem === 1'b1) n_be++;
      if (i == 0) chk("t4_start_first", {15'd0, mc_start}, 16'd1);
      if (i == 5) chk("t4_exit_ctl", {13'd0, stall_front, hold_idex, bubble_exmem}, 16'd0);
      tick();
    end
    mc_done = 1'b0;
    chk("t4_start_count", 16'(n_start), 16'd1);
    chk("t4_stall_count", 16'(n_stall), 16'd5);
    chk("t4_bubble_exmem_count", 16'(n_be), 16'd5);
    chk("t4_no_timeout", {15'd0, mc_timeout}, 16'd0);
    chk("t4_consumer_fwd_mc", {14'd0, f_rs1}, 16'h0001);
    nop();
    #1 chk("t4_back_to_run", {14'd0, stall_front, hold_idex}, 16'd0);
    tick();

    // watchdog: done never arrives, limit 8
    idrv(1, 5'd1, 5'd2, 1, 1, 5'd8, 1, 0, 1);
    tick();
    nop();
    n_start = 0; n_stall = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (mc_start === 1'b1) n_start++;
      if (stall_front === 1'b1) n_stall++;
      if (i == 7) chk("t5_wd_exit_ctl", {14'd0, stall_front, hold_idex}, 16'd0);
      tick();
    end
    chk("t5_wd_start_count", 16'(n_start), 16'd1);
    chk("t5_wd_stall_count", 16'(n_stall), 16'd7);
    chk("t5_timeout_set", {15'd0, mc_timeout}, 16'd1);
    repeat (3) tick();
    chk("t5_timeout_sticky", {15'd0, mc_timeout}, 16'd1);
    chk("t5_run_after_wd", {14'd0, stall_front, hold_idex}, 16'd0);

    // branch with dependent load consumer in ID
    idrv(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1, 0);
    tick();
    idrv(1, 5'd3, 5'd0, 1, 0, 5'd4, 1, 0, 0);
    branch_taken = 1'b1;
    #1 chk("t6_br_flush_bubble", {14'd0, flush_ifid, bubble_idex}, 16'h0003);
    chk("t6_br_no_lu_stall", {15'd0, stall_front}, 16'd0);
    tick();
    branch_taken = 1'b0;
    nop();
    #1 chk("t6_br_after_ctl", {14'd0, stall_front, bubble_idex}, 16'd0);
    chk("t6_br_selects", {12'd0, f_rs1, f_rs2}, 16'h0000);

    // branch discards an mc op in ID
    idrv(1, 5'd1, 5'd2, 1, 1, 5'd8, 1, 0, 1);
    branch_taken = 1'b1;
    #1 chk("t6_br_mc_flush", {15'd0, flush_ifid}, 16'd1);
    tick();
    branch_taken = 1'b0;
    nop();
    #1 chk("t6_br_no_mc_entry", {14'd0, stall_front, mc_start}, 16'd0);
    tick();

    // reset in the middle of MC_BUSY
    idrv(1, 5'd1, 5'd2, 1, 1, 5'd8, 1, 0, 1);
    tick();
    nop();
    tick();
    #1 chk("t6_busy_before_reset", {14'd0, stall_front, hold_idex}, 16'h0003);
    reset_n = 1'b0;
    #1 chk("t6_reset_mid_mc_all", all_out(), 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    #1 chk("t6_no_restart", {14'd0, stall_front, mc_start}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
